// File: rtl/img_stream_tx.sv
// Image RAM plus a raster replay engine that feeds the CNN forward-pass pipeline.
// Optional zero border around each pass: define IMG_STREAM_PAD_EN.
module img_stream_tx #(
    parameter int DATA_W   = 8,
    parameter int IMG_W    = 28,
    parameter int IMG_H    = 28,
    parameter int ADDR_W   = 10,
    parameter int NUM_PASS = 1,
    parameter int LINE_GAP = 0,
    parameter int PASS_GAP = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] ima,
    output logic              ena,
    output logic              line_start,
    output logic              frame_start,
    output logic              frame_end,
    output logic              frame_start_dim,
    output logic              frame_end_dim
);

`ifdef IMG_STREAM_PAD_EN
    localparam int PAD = 1;
`else
    localparam int PAD = 0;
`endif

    localparam int FW      = IMG_W + 2 * PAD;
    localparam int FH      = IMG_H + 2 * PAD;
    localparam int NPIX    = IMG_W * IMG_H;
    localparam int COL_W   = $clog2(FW + 1);
    localparam int ROW_W   = $clog2(FH + 1);
    localparam int PASS_W  = $clog2(NUM_PASS + 1);
    localparam int GAP_MAX = (LINE_GAP > PASS_GAP) ? LINE_GAP : PASS_GAP;
    localparam int GAP_W   = $clog2(GAP_MAX + 2);

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(FW - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(FH - 1);
    localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(NUM_PASS - 1);
    localparam logic [GAP_W-1:0]  LGAP_LAST = GAP_W'((LINE_GAP > 0) ? LINE_GAP - 1 : 0);
    localparam logic [GAP_W-1:0]  PGAP_LAST = GAP_W'((PASS_GAP > 0) ? PASS_GAP - 1 : 0);
    localparam logic [ADDR_W:0]   NPIX_V    = (ADDR_W + 1)'(NPIX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STREAM,
        S_LGAP,
        S_PGAP,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [COL_W-1:0]    r_col;
    logic [ROW_W-1:0]    r_row;
    logic [PASS_W-1:0]   r_pass;
    logic [GAP_W-1:0]    r_gap;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_mem [2**ADDR_W];
    logic [DATA_W-1:0]   r_rd_data;

    logic                r_s1_vld, r_s1_pad, r_s1_ls, r_s1_fs, r_s1_fe, r_s1_fsd, r_s1_fed;
    logic                r_busy, r_done, r_ena, r_ls, r_fs, r_fe, r_fsd, r_fed;
    logic [DATA_W-1:0]   r_ima;

    logic                w_col0, w_row0, w_col_last, w_row_last, w_pass_last;
    logic                w_interior, w_start_ok, w_wr_ok;

    assign w_col0      = (r_col == '0);
    assign w_row0      = (r_row == '0);
    assign w_col_last  = (r_col == COL_LAST);
    assign w_row_last  = (r_row == ROW_LAST);
    assign w_pass_last = (r_pass == PASS_LAST);

`ifdef IMG_STREAM_PAD_EN
    assign w_interior = !w_row0 && !w_row_last && !w_col0 && !w_col_last;
`else
    assign w_interior = 1'b1;
`endif

    // done must have cleared too: a start in the done cycle is dropped
    assign w_start_ok = (r_state == S_IDLE) && start && !r_busy && !r_done;
    assign w_wr_ok    = wr_en && !r_busy && ({1'b0, wr_addr} < NPIX_V);

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[wr_addr] <= wr_data;
        end
        r_rd_data <= r_mem[r_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) w_state_nxt = S_STREAM;
            end
            S_STREAM: begin
                if (w_col_last) begin
                    if (w_row_last) begin
                        if (w_pass_last)       w_state_nxt = S_DONE;
                        else if (PASS_GAP > 0) w_state_nxt = S_PGAP;
                    end else if (LINE_GAP > 0) begin
                        w_state_nxt = S_LGAP;
                    end
                end
            end
            S_LGAP:  if (r_gap == LGAP_LAST) w_state_nxt = S_STREAM;
            S_PGAP:  if (r_gap == PGAP_LAST) w_state_nxt = S_STREAM;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // read address advances only on interior beats, so padding leaves RAM layout untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col  <= '0;
            r_row  <= '0;
            r_pass <= '0;
            r_gap  <= '0;
            r_addr <= '0;
        end else begin
            case (r_state)
                S_STREAM: begin
                    r_gap <= '0;
                    if (w_interior) r_addr <= r_addr + 1'b1;
                    if (w_col_last) begin
                        r_col <= '0;
                        if (w_row_last) begin
                            r_row  <= '0;
                            r_addr <= '0;
                            if (!w_pass_last) r_pass <= r_pass + 1'b1;
                        end else begin
                            r_row <= r_row + 1'b1;
                        end
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end
                S_LGAP, S_PGAP: r_gap <= r_gap + 1'b1;
                default: begin
                    r_col  <= '0;
                    r_row  <= '0;
                    r_pass <= '0;
                    r_gap  <= '0;
                    r_addr <= '0;
                end
            endcase
        end
    end

    // stage 1 sideband travels alongside the synchronous RAM read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld <= 1'b0;
            r_s1_pad <= 1'b0;
            r_s1_ls  <= 1'b0;
            r_s1_fs  <= 1'b0;
            r_s1_fe  <= 1'b0;
            r_s1_fsd <= 1'b0;
            r_s1_fed <= 1'b0;
        end else begin
            r_s1_vld <= (r_state == S_STREAM);
            r_s1_pad <= !w_interior;
            r_s1_ls  <= w_col0;
            r_s1_fsd <= w_col0 && w_row0;
            r_s1_fed <= w_col_last && w_row_last;
            r_s1_fs  <= w_col0 && w_row0 && (r_pass == '0);
            r_s1_fe  <= w_col_last && w_row_last && w_pass_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ena  <= 1'b0;
            r_ima  <= '0;
            r_ls   <= 1'b0;
            r_fs   <= 1'b0;
            r_fe   <= 1'b0;
            r_fsd  <= 1'b0;
            r_fed  <= 1'b0;
            r_done <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_ena  <= r_s1_vld;
            r_ima  <= (r_s1_vld && !r_s1_pad) ? r_rd_data : '0;
            r_ls   <= r_s1_vld && r_s1_ls;
            r_fs   <= r_s1_vld && r_s1_fs;
            r_fe   <= r_s1_vld && r_s1_fe;
            r_fsd  <= r_s1_vld && r_s1_fsd;
            r_fed  <= r_s1_vld && r_s1_fed;
            r_done <= r_fe;
            if (w_start_ok)  r_busy <= 1'b1;
            else if (r_fe)   r_busy <= 1'b0;
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign ima             = r_ima;
    assign ena             = r_ena;
    assign line_start      = r_ls;
    assign frame_start     = r_fs;
    assign frame_end       = r_fe;
    assign frame_start_dim = r_fsd;
    assign frame_end_dim   = r_fed;

endmodule

// File: tb/tb_img_stream_tx.sv
// Directed bench: default, line-gap and two-pass instances share one loader and start line.
module tb_img_stream_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [9:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       start = 1'b0;

    logic       busy_a, done_a, ena_a, ls_a, fs_a, fe_a, fsd_a, fed_a;
    logic       busy_b, done_b, ena_b, ls_b, fs_b, fe_b, fsd_b, fed_b;
    logic       busy_c, done_c, ena_c, ls_c, fs_c, fe_c, fsd_c, fed_c;
    logic [7:0] ima_a, ima_b, ima_c;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int st_cyc = 0;

    int         ilog_a [2048], ilog_b [2048], ilog_c [2048];
    int         clog_a [2048], clog_b [2048], clog_c [2048];
    logic [4:0] flog_a [2048], flog_b [2048], flog_c [2048];
    int n_a, n_b, n_c, viol_a, viol_b, viol_c, nd_a, nd_b, nd_c, dcyc_a, dcyc_b, dcyc_c;
    int nls_a, nls_b, nfs_c, nfe_a, nfe_c, nfsd_c, nfed_c;

    typedef struct {
        int         dut;
        int         beat;
        int         ima;
        logic [4:0] flg;
    } vec_t;
    vec_t tv [17];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    img_stream_tx u_a (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .busy(busy_a), .done(done_a), .ima(ima_a), .ena(ena_a),
        .line_start(ls_a), .frame_start(fs_a), .frame_end(fe_a),
        .frame_start_dim(fsd_a), .frame_end_dim(fed_a)
    );

    img_stream_tx #(.LINE_GAP(3)) u_b (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .busy(busy_b), .done(done_b), .ima(ima_b), .ena(ena_b),
        .line_start(ls_b), .frame_start(fs_b), .frame_end(fe_b),
        .frame_start_dim(fsd_b), .frame_end_dim(fed_b)
    );

    img_stream_tx #(.NUM_PASS(2), .PASS_GAP(2)) u_c (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .busy(busy_c), .done(done_c), .ima(ima_c), .ena(ena_c),
        .line_start(ls_c), .frame_start(fs_c), .frame_end(fe_c),
        .frame_start_dim(fsd_c), .frame_end_dim(fed_c)
    );

    // beat recorders, flags packed as {line_start, frame_start, frame_end, start_dim, end_dim}
    always @(negedge clk) begin
        if (ena_a) begin
            if (n_a < 2048) begin
                ilog_a[n_a] = int'(ima_a);
                flog_a[n_a] = {ls_a, fs_a, fe_a, fsd_a, fed_a};
                clog_a[n_a] = cyc;
            end
            n_a = n_a + 1;
            if (ls_a) nls_a = nls_a + 1;
            if (fe_a) nfe_a = nfe_a + 1;
        end else if (ima_a != 8'd0 || {ls_a, fs_a, fe_a, fsd_a, fed_a} != 5'd0) begin
            viol_a = viol_a + 1;
        end
        if (done_a) begin
            nd_a = nd_a + 1;
            dcyc_a = cyc;
        end
    end

    always @(negedge clk) begin
        if (ena_b) begin
            if (n_b < 2048) begin
                ilog_b[n_b] = int'(ima_b);
                flog_b[n_b] = {ls_b, fs_b, fe_b, fsd_b, fed_b};
                clog_b[n_b] = cyc;
            end
            n_b = n_b + 1;
            if (ls_b) nls_b = nls_b + 1;
        end else if (ima_b != 8'd0 || {ls_b, fs_b, fe_b, fsd_b, fed_b} != 5'd0) begin
            viol_b = viol_b + 1;
        end
        if (done_b) begin
            nd_b = nd_b + 1;
            dcyc_b = cyc;
        end
    end

    always @(negedge clk) begin
        if (ena_c) begin
            if (n_c < 2048) begin
                ilog_c[n_c] = int'(ima_c);
                flog_c[n_c] = {ls_c, fs_c, fe_c, fsd_c, fed_c};
                clog_c[n_c] = cyc;
            end
            n_c = n_c + 1;
            if (fs_c)  nfs_c  = nfs_c + 1;
            if (fe_c)  nfe_c  = nfe_c + 1;
            if (fsd_c) nfsd_c = nfsd_c + 1;
            if (fed_c) nfed_c = nfed_c + 1;
        end else if (ima_c != 8'd0 || {ls_c, fs_c, fe_c, fsd_c, fed_c} != 5'd0) begin
            viol_c = viol_c + 1;
        end
        if (done_c) begin
            nd_c = nd_c + 1;
            dcyc_c = cyc;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic clear_logs();
        n_a = 0; n_b = 0; n_c = 0;
        viol_a = 0; viol_b = 0; viol_c = 0;
        nd_a = 0; nd_b = 0; nd_c = 0;
        dcyc_a = 0; dcyc_b = 0; dcyc_c = 0;
        nls_a = 0; nls_b = 0; nfe_a = 0;
        nfs_c = 0; nfe_c = 0; nfsd_c = 0; nfed_c = 0;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        st_cyc = cyc + 1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_all(input int bound);
        int k = 0;
        while (!(nd_a > 0 && nd_b > 0 && nd_c > 0) && k < bound) begin
            tick();
            k++;
        end
        chk("all_done_in_time", int'(nd_a > 0 && nd_b > 0 && nd_c > 0), 1);
    endtask

    function automatic int get_ima(input int d, input int b);
        case (d)
            0:       return ilog_a[b];
            1:       return ilog_b[b];
            default: return ilog_c[b];
        endcase
    endfunction

    function automatic int get_flg(input int d, input int b);
        case (d)
            0:       return int'(flog_a[b]);
            1:       return int'(flog_b[b]);
            default: return int'(flog_c[b]);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0]  = '{0, 0,    0,   5'b11010};
        tv[1]  = '{0, 1,    1,   5'b00000};
        tv[2]  = '{0, 27,   27,  5'b00000};
        tv[3]  = '{0, 28,   28,  5'b10000};
        tv[4]  = '{0, 255,  255, 5'b00000};
        tv[5]  = '{0, 256,  0,   5'b00000};
        tv[6]  = '{0, 280,  24,  5'b10000};
        tv[7]  = '{0, 511,  255, 5'b00000};
        tv[8]  = '{0, 756,  244, 5'b10000};
        tv[9]  = '{0, 782,  14,  5'b00000};
        tv[10] = '{0, 783,  15,  5'b00101};
        tv[11] = '{1, 28,   28,  5'b10000};
        tv[12] = '{1, 783,  15,  5'b00101};
        tv[13] = '{2, 0,    0,   5'b11010};
        tv[14] = '{2, 783,  15,  5'b00001};
        tv[15] = '{2, 784,  0,   5'b10010};
        tv[16] = '{2, 1567, 15,  5'b00101};

        clear_logs();
        repeat (3) tick();
        chk("reset_outputs_a", int'({busy_a, done_a, ena_a, ima_a, ls_a, fs_a, fe_a, fsd_a, fed_a}), 0);
        chk("reset_outputs_c", int'({busy_c, done_c, ena_c, ima_c, ls_c, fs_c, fe_c, fsd_c, fed_c}), 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 784; i++) begin
            wr_en   = 1'b1;
            wr_addr = 10'(i);
            wr_data = 8'(i);
            tick();
        end
        wr_en = 1'b0;
        tick();

        // basic frame, line gaps and two passes all run from one start
        clear_logs();
        start_pulse();
        chk("busy_after_start", int'(busy_a), 1);
        wait_all(4000);
        for (int i = 0; i < 17; i++) begin
            chk($sformatf("ima_d%0d_b%0d", tv[i].dut, tv[i].beat), get_ima(tv[i].dut, tv[i].beat), tv[i].ima);
            chk($sformatf("flags_d%0d_b%0d", tv[i].dut, tv[i].beat), get_flg(tv[i].dut, tv[i].beat), int'(tv[i].flg));
        end
        chk("a_beats", n_a, 784);
        chk("a_first_latency", clog_a[0] - st_cyc, 2);
        chk("a_contiguous", clog_a[783] - clog_a[0], 783);
        chk("a_done_after_last", dcyc_a - clog_a[783], 1);
        chk("a_line_starts", nls_a, 28);
        chk("a_idle_strobes", viol_a, 0);
        chk("a_busy_low", int'(busy_a), 0);
        chk("b_beats", n_b, 784);
        chk("b_span", clog_b[783] - clog_b[0] + 1, 865);
        chk("b_line0_contig", clog_b[27] - clog_b[0], 27);
        chk("b_gap_cycles", clog_b[28] - clog_b[27], 4);
        chk("b_no_final_gap", dcyc_b - clog_b[783], 1);
        chk("b_line_starts", nls_b, 28);
        chk("b_idle_strobes", viol_b, 0);
        chk("c_beats", n_c, 1568);
        chk("c_pass_gap", clog_c[784] - clog_c[783], 3);
        chk("c_frame_start_cnt", nfs_c, 1);
        chk("c_frame_end_cnt", nfe_c, 1);
        chk("c_start_dim_cnt", nfsd_c, 2);
        chk("c_end_dim_cnt", nfed_c, 2);
        chk("c_idle_strobes", viol_c, 0);
        repeat (3) tick();

        // start and RAM write during a transfer must both be dropped
        clear_logs();
        start_pulse();
        for (int k = 0; k < 500 && n_a < 100; k++) tick();
        chk("a_reached_100", int'(n_a >= 100), 1);
        start   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = '0;
        wr_data = 8'hFF;
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        for (int k = 0; k < 2000 && !done_a; k++) tick();
        chk("a_done_seen", int'(done_a), 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk("done_cycle_start_ignored", int'(busy_a), 0);
        wait_all(4000);
        chk("a_beats_busy_start", n_a, 784);
        chk("a_contig_busy_start", clog_a[783] - clog_a[0], 783);
        chk("a_single_done", nd_a, 1);
        chk("c_single_done", nd_c, 1);
        chk("c_pass2_pixel0", ilog_c[784], 0);
        chk("c_pass1_pixel0", ilog_c[0], 0);
        repeat (3) tick();

        // reset in the middle of a frame
        clear_logs();
        start_pulse();
        for (int k = 0; k < 1000 && n_a < 400; k++) tick();
        chk("a_reached_400", int'(n_a >= 400), 1);
        rst_n = 1'b0;
        #1;
        chk("midreset_outputs_a", int'({busy_a, done_a, ena_a, ima_a, ls_a, fs_a, fe_a, fsd_a, fed_a}), 0);
        chk("midreset_outputs_b", int'({busy_b, done_b, ena_b, ima_b, ls_b, fs_b, fe_b, fsd_b, fed_b}), 0);
        chk("midreset_no_frame_end", nfe_a, 0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("post_reset_busy", int'(busy_a), 0);
        chk("post_reset_no_done", nd_a, 0);
        clear_logs();
        start_pulse();
        wait_all(4000);
        chk("restart_beats", n_a, 784);
        chk("restart_latency", clog_a[0] - st_cyc, 2);
        chk("restart_pixel0", ilog_a[0], 0);
        chk("restart_pixel400", ilog_a[400], 144);
        chk("restart_pixel783", ilog_a[783], 15);
        chk("restart_flags0", int'(flog_a[0]), 26);
        chk("restart_frame_end", nfe_a, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
